serializador_10b: RTL and testbench
===================================

# serializador_10b

Parallel-to-serial stage directly downstream of the 8b/10b encoder. It accepts one 10-bit code group per handshake from the encoder's `salidas` output and shifts it out MSB-first, one bit per `clk`. When no data word is pending it transmits a comma/idle code group, so the line never carries undefined bits. A word-boundary strobe marks the first bit of every code group for the downstream line driver and for the receiver-side test benches.

## Interface
Parameters:
- `ANCHO`, 10, code-group width in bits; the counter and shift register are sized from it.
- `PALABRA_IDLE`, `10'b0011111010`, K28.5 (RD−) code group sent whenever no data is pending.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enb`  in  1  enable; 0 freezes all state.
- `entradas`  in  ANCHO  code group from the encoder.
- `valido`  in  1  `entradas` holds a valid word.
- `listo`  out  1  block can accept a word this cycle.
- `serie`  out  1  serial bit stream.
- `inicio`  out  1  high during the cycle in which `serie` carries bit ANCHO-1 of a code group.
- `conteo_idle`  out  16  number of idle code groups inserted. Present only with `SERIALIZADOR_CONTADOR_EN` (see Configuration).

## Operation
- **State:**
  - shift register `desp[ANCHO-1:0]`
  - bit counter `cont` (0..ANCHO-1)
  - holding buffer `buf[ANCHO-1:0]` with flag `lleno`
- **Outputs:**
  - `serie` = `desp[ANCHO-1]`, taken directly from the register.
  - `inicio` is registered.
- **Handshake:**
  - `listo = enb & (!lleno | cont==ANCHO-1)`, combinational.
  - A transfer occurs on any rising edge where `valido & listo`.
  - A sender seeing `listo=0` holds `entradas` and `valido` stable.
- **Enabled edge with `cont != ANCHO-1` (mid-word):**
  - `desp <= desp << 1`, `cont <= cont+1`, `inicio <= 0`.
  - On a transfer: `buf <= entradas`, `lleno <= 1`.
- **Enabled edge with `cont == ANCHO-1` (load edge):** `cont <= 0` and `inicio <= 1`. The value loaded into `desp` depends on the buffer and on whether a transfer occurs:
  - Buffer full, no transfer: `desp <= buf`, `lleno <= 0`.
  - Buffer full, transfer: `desp <= buf`, `buf <= entradas`, `lleno` stays 1.
  - Buffer empty, transfer: bypass, `desp <= entradas`, `lleno` stays 0.
  - Buffer empty, no transfer: `desp <= PALABRA_IDLE`.
- **`enb=0`:** `desp`, `cont`, `buf`, `lleno` and `inicio` hold their values; `listo=0`.

## Timing
- **Reset values (while `rst=0`, immediately, asynchronously):**
  - `desp=0`, `serie=0`, `inicio=0`, `cont=ANCHO-1`, `lleno=0`.
  - `conteo_idle=0` when the macro is defined.
  - `listo` follows `enb`, because `cont=ANCHO-1`.
- **After reset release:** the first enabled edge is a load edge. Idle (or a bypassed word) starts there.
- **Word period:** exactly ANCHO enabled cycles; `inicio` pulses once every ANCHO enabled cycles.
- **Latency:**
  - A word transferred on a load edge (bypass) appears on `serie` in the following cycle.
  - A word transferred mid-word appears at the next load edge; worst case ANCHO-1 cycles of wait.
- **Throughput:** with `valido` held high continuously, words go out back-to-back with no idle between them.
- **Reset asserted mid-word:** the current word and the buffered word are discarded; nothing partial is retransmitted.
- **`enb` low mid-word:** transmission resumes with the remaining bits. A word is never split by an inserted idle.

## Configuration
- **`SERIALIZADOR_CONTADOR_EN` defined:**
  - Port `conteo_idle[15:0]` exists.
  - It increments on every load edge that loads `PALABRA_IDLE`.
  - It saturates at `16'hFFFF`.
- **Not defined:** the port and the counter are absent; all other behaviour is identical.

## Test plan
- **Reset and idle:** `rst=0` for 3 cycles, then `rst=1`, `enb=1`, `valido=0`.
  - During reset: `serie=0`, `inicio=0`.
  - Afterwards: `serie` repeats 0,0,1,1,1,1,1,0,1,0 with `inicio` high on every 10th cycle.
- **Single mid-word word:** `entradas=10'b1001110100` (D0.0), `valido` for 1 cycle at `cont=3`.
  - `listo` drops after the transfer.
  - The word appears on `serie` after the current idle word completes.
  - Idle resumes afterwards.
- **Back-to-back:** `valido` held with `10'b1001110100`, `10'b0111010100`, `10'b1011010100` changed on each transfer.
  - 30 consecutive cycles of data, no `PALABRA_IDLE` between words.
  - `listo` high only on load edges once the buffer is full.
- **Enable freeze:** `enb=0` for 7 cycles mid-word.
  - `serie`, `inicio` and `cont` are frozen and `listo=0`.
  - After `enb=1`, the remaining bits follow with no loss.
- **Reset mid-transfer:** `rst=0` at `cont=5` with the buffer full.
  - `serie=0` and `lleno=0` immediately.
  - After release, the first word sent is idle.
- **With `SERIALIZADOR_CONTADOR_EN`:**
  - 5 idle words after reset give `conteo_idle=5`.
  - With the counter preloaded via force to `16'hFFFE`, `conteo_idle` reaches `16'hFFFF` and stays there.

Source files
------------

// File: rtl/serializador_10b.sv
// serializador_10b: 10-bit code-group serializer, MSB-first, idle insertion when no word is pending
// Ports: clk, rst (async active-low), enb (0 freezes), entradas/valido/listo (input handshake),
//        serie (serial bit), inicio (first-bit strobe), conteo_idle (idle count, SERIALIZADOR_CONTADOR_EN only)
module serializador_10b #(
   parameter int                 ANCHO        = 10,
   parameter logic [ANCHO-1:0]   PALABRA_IDLE = 10'b0011111010
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enb,
   input  logic [ANCHO-1:0] entradas,
   input  logic             valido,
   output logic             listo,
   output logic             serie,
   output logic             inicio
`ifdef SERIALIZADOR_CONTADOR_EN
   ,output logic [15:0]     conteo_idle
`endif
);
   localparam int             CW  = $clog2(ANCHO);
   localparam logic [CW-1:0]  ULT = CW'(ANCHO - 1);
   logic [ANCHO-1:0] desp, desp_n, bufer, bufer_n;
   logic [CW-1:0]    cont, cont_n;
   logic             lleno, lleno_n, inicio_n, fin, xfer;
   assign serie = desp[ANCHO-1];
   always_comb begin
      fin      = cont == ULT;
      listo    = enb & (!lleno | fin);
      xfer     = valido & listo;
      desp_n   = desp;
      cont_n   = cont;
      bufer_n  = bufer;
      lleno_n  = lleno;
      inicio_n = inicio;
      if (enb) begin
         if (!fin) begin
            desp_n   = desp << 1;
            cont_n   = cont + 1'b1;
            inicio_n = 1'b0;
            if (xfer) begin
               bufer_n = entradas;
               lleno_n = 1'b1;
            end
         end else begin
            cont_n   = '0;
            inicio_n = 1'b1;
            // buffered word has priority; an empty buffer lets a fresh word bypass straight into desp
            if (lleno) begin
               desp_n = bufer;
               if (xfer) bufer_n = entradas;
               else      lleno_n = 1'b0;
            end else begin
               desp_n = xfer ? entradas : PALABRA_IDLE;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         desp   <= '0;
         cont   <= ULT;
         bufer  <= '0;
         lleno  <= 1'b0;
         inicio <= 1'b0;
      end else begin
         desp   <= desp_n;
         cont   <= cont_n;
         bufer  <= bufer_n;
         lleno  <= lleno_n;
         inicio <= inicio_n;
      end
   end
`ifdef SERIALIZADOR_CONTADOR_EN
   // counts load edges that fall back to the idle group, saturating at all-ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         conteo_idle <= '0;
      else if (enb && fin && !lleno && !xfer && conteo_idle != 16'hFFFF)
         conteo_idle <= conteo_idle + 16'd1;
   end
`endif
endmodule

// File: tb/tb_serializador_10b.sv
// tb_serializador_10b: scoreboard bench for serializador_10b against a word-slot queue model
module tb_serializador_10b;
   localparam logic [9:0] IDLE = 10'b0011111010;
   typedef struct {
      logic        s;
      logic        i;
      logic        l;
      logic [15:0] c;
   } exp_t;
   logic clk = 0, rst = 1, enb = 0, valido = 0;
   logic [9:0] entradas = '0;
   logic listo, serie, inicio;
`ifdef SERIALIZADOR_CONTADOR_EN
   logic [15:0] conteo_idle;
`endif
   int checks = 0, errors = 0;
   logic [9:0] pend[$];
   logic [9:0] cur = '0;
   int ph = 0;
   bit xfer_seen = 0;
   logic e_serie = 0, e_inicio = 0;
   logic [15:0] m_cnt = '0;
   exp_t expq[$];

   serializador_10b u_dut (
      .clk(clk), .rst(rst), .enb(enb), .entradas(entradas), .valido(valido),
      .listo(listo), .serie(serie), .inicio(inicio)
`ifdef SERIALIZADOR_CONTADOR_EN
      ,.conteo_idle(conteo_idle)
`endif
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endfunction

   // model: the line is a sequence of 10-cycle word slots; each slot carries the oldest
   // accepted word not yet sent, or the idle group if none is waiting
   task automatic step();
      exp_t e;
      @(posedge clk);
      xfer_seen = 0;
      if (!rst) begin
         pend.delete();
         ph = 0;
         cur = '0;
         e_serie = 0;
         e_inicio = 0;
         m_cnt = '0;
      end else if (enb) begin
         if (valido && (pend.size() == 0 || ph == 0)) begin
            pend.push_back(entradas);
            xfer_seen = 1;
         end
         if (ph == 0) begin
            if (pend.size() != 0) cur = pend.pop_front();
            else begin
               cur = IDLE;
               if (m_cnt != 16'hFFFF) m_cnt++;
            end
         end
         e_inicio = (ph == 0);
         e_serie = cur[9-ph];
         ph = (ph + 1) % 10;
      end
      e.s = e_serie;
      e.i = e_inicio;
      e.l = enb & (pend.size() == 0 || ph == 0);
      e.c = m_cnt;
      expq.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [9:0] w);
      int n = 0;
      valido = 1;
      entradas = w;
      do begin
         step();
         n++;
      end while (!xfer_seen && n < 40);
      if (!xfer_seen) chk("send_timeout", 16'(n), 16'd0);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("serie", 16'(serie), 16'(e.s));
            chk("inicio", 16'(inicio), 16'(e.i));
            chk("listo", 16'(listo), 16'(e.l));
`ifdef SERIALIZADOR_CONTADOR_EN
            chk("conteo_idle", conteo_idle, e.c);
`endif
         end
      end
   end

   initial begin
      int n;
      #2 rst = 0;
      #1;
      chk("reset_serie", 16'(serie), 16'd0);
      chk("reset_inicio", 16'(inicio), 16'd0);
      repeat (3) step();
      rst = 1;
      enb = 1;
      repeat (25) step();
      while (ph != 4) step();
      valido = 1;
      entradas = 10'b1001110100;
      step();
      valido = 0;
      repeat (25) step();
      send(10'b1001110100);
      send(10'b0111010100);
      send(10'b1011010100);
      valido = 0;
      repeat (40) step();
      send(10'b1101001011);
      valido = 0;
      while (ph != 1) step();
      while (ph != 4) step();
      enb = 0;
      repeat (7) step();
      enb = 1;
      repeat (20) step();
      send(10'b0101010101);
      send(10'b1100110011);
      valido = 0;
      n = 0;
      while (!(ph == 6 && pend.size() == 1) && n < 40) begin
         step();
         n++;
      end
      chk("setup_full_buffer", 16'(u_dut.lleno), 16'd1);
      rst = 0;
      #1;
      chk("midreset_serie", 16'(serie), 16'd0);
      chk("midreset_lleno", 16'(u_dut.lleno), 16'd0);
      chk("midreset_inicio", 16'(inicio), 16'd0);
      repeat (2) step();
      rst = 1;
      repeat (30) step();
      repeat (500) begin
         enb = ($urandom_range(0, 7) != 0);
         if (!valido && $urandom_range(0, 2) == 0) begin
            valido = 1;
            entradas = 10'($urandom);
         end
         step();
         if (xfer_seen) begin
            if ($urandom_range(0, 1) == 0) entradas = 10'($urandom);
            else valido = 0;
         end
      end
      valido = 0;
      enb = 1;
`ifdef SERIALIZADOR_CONTADOR_EN
      force u_dut.conteo_idle = 16'hFFFE;
      release u_dut.conteo_idle;
      m_cnt = 16'hFFFE;
      repeat (40) step();
`endif
      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
